// File: rtl/sine_dds_if.sv
// Oscillator bus: sample-rate control, ROM read port and the sample stream to the mixer.
interface sine_dds_if #(
    parameter int PHASE_W = 32
);
    logic               tick;
    logic [PHASE_W-1:0] tw;
    logic               phase_clr;
    logic               rom_en;
    logic [8:0]         rom_addr;
    logic [15:0]        rom_dout;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;

    // Oscillator side
    modport master (
        input  tick, tw, phase_clr, rom_dout, sample_ready,
        output rom_en, rom_addr, sample_out, sample_valid, overrun
    );

    // Environment side: sequencer, ROM and mixer
    modport slave (
        output tick, tw, phase_clr, rom_dout, sample_ready,
        input  rom_en, rom_addr, sample_out, sample_valid, overrun
    );
endinterface

// File: rtl/sine_dds.sv
// Wavetable sine oscillator: phase accumulator, one or two ROM reads per sample,
// optional linear interpolation, valid/ready sample output.
module sine_dds #(
    parameter int PHASE_W = 32,
    parameter bit INTERP  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sine_dds_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQA, REQB, CAPB, MUL, OUT, CAPA} state_t;

    state_t             state, nxt;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         idx, frac;
    logic [15:0]        a, b;
    logic               accept;
    logic [7:0]         cur_idx, cur_frac;
    logic signed [16:0] d;
    logic signed [25:0] p;
    logic [15:0]        y;

    // A tick is only taken while idle; phase_clr alongside it means "start from zero"
    assign accept   = (state == IDLE) && bus.tick;
    assign cur_idx  = bus.phase_clr ? 8'd0 : phase[PHASE_W-1 -: 8];
    assign cur_frac = bus.phase_clr ? 8'd0 : phase[PHASE_W-9 -: 8];

    assign bus.rom_en       = (state == REQA) || (state == REQB);
    assign bus.sample_valid = (state == OUT);

    // Interpolation: y = a + floor((b - a) * frac / 256); the result never leaves 0..65535
    always_comb begin
        d = $signed({1'b0, b}) - $signed({1'b0, a});
        p = 26'(d) * 26'($signed({1'b0, frac}));
        y = a + 16'(p >>> 8);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state sequencing through the read / interpolate / output steps
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (bus.tick) nxt = REQA;
            REQA: nxt = INTERP ? REQB : CAPA;
            REQB: nxt = CAPB;
            CAPB: nxt = MUL;
            MUL:  nxt = OUT;
            CAPA: nxt = OUT;
            OUT:  if (bus.sample_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Phase accumulator; a clear outside an accepted tick never touches the in-flight sample
    always_ff @(posedge clk) begin
        if (rst)                phase <= '0;
        else if (accept)        phase <= bus.phase_clr ? bus.tw : phase + bus.tw;
        else if (bus.phase_clr) phase <= '0;
    end

    // Snapshot of the pre-increment phase fields for the sample being built
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            frac <= '0;
        end else if (accept) begin
            idx  <= cur_idx;
            frac <= cur_frac;
        end
    end

    // ROM address is loaded ahead of REQA/REQB so it is on the pins during those states
    always_ff @(posedge clk) begin
        if (rst)                           bus.rom_addr <= '0;
        else if (accept)                   bus.rom_addr <= {1'b0, cur_idx};
        else if (state == REQA && INTERP)  bus.rom_addr <= {1'b0, idx + 8'd1};
    end

    // Capture the two table entries as they return from the ROM
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
        end else begin
            if (state == REQB) a <= bus.rom_dout;
            if (state == CAPB) b <= bus.rom_dout;
        end
    end

    // Output sample: offset-binary to two's complement by flipping the MSB; held through OUT
    always_ff @(posedge clk) begin
        if (rst)                 bus.sample_out <= '0;
        else if (state == MUL)   bus.sample_out <= {~y[15], y[14:0]};
        else if (state == CAPA)  bus.sample_out <= {~bus.rom_dout[15], bus.rom_dout[14:0]};
    end

    // Sticky flag for ticks lost while a sample was in progress
    always_ff @(posedge clk) begin
        if (rst)                             bus.overrun <= 1'b0;
        else if (bus.tick && state != IDLE)  bus.overrun <= 1'b1;
    end
endmodule
